// File: rtl/mat_operand_fetch.sv
// Operand fetch stage for the matrix multiplier: turns (row, col) requests into
// linear word addresses for two synchronous-read memories and realigns the returned data.
module mat_operand_fetch #(
    parameter int I_WIDTH        = 16,
    parameter int F_WIDTH        = 16,
    parameter int SPECTRAL_BANDS = 103,
    parameter int ADDR_WIDTH     = 14,
    parameter int READ_LATENCY   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_WIDTH-1:0]                mat1_base,
    input  logic [ADDR_WIDTH-1:0]                mat2_base,
    input  logic [$clog2(SPECTRAL_BANDS):0]      mat1_stride,
    input  logic [$clog2(SPECTRAL_BANDS):0]      mat2_stride,
    input  logic                                 mat2_transpose,
    input  logic                                 rd_addr_valid,
    input  logic [$clog2(SPECTRAL_BANDS)-1:0]    mat1_row,
    input  logic [$clog2(SPECTRAL_BANDS)-1:0]    mat1_col,
    input  logic [$clog2(SPECTRAL_BANDS)-1:0]    mat2_row,
    input  logic [$clog2(SPECTRAL_BANDS)-1:0]    mat2_col,
    output logic                                 mem1_en,
    output logic                                 mem2_en,
    output logic [ADDR_WIDTH-1:0]                mem1_addr,
    output logic [ADDR_WIDTH-1:0]                mem2_addr,
    input  logic [I_WIDTH+F_WIDTH-1:0]           mem1_rdata,
    input  logic [I_WIDTH+F_WIDTH-1:0]           mem2_rdata,
    output logic [I_WIDTH+F_WIDTH-1:0]           mat1,
    output logic [I_WIDTH+F_WIDTH-1:0]           mat2,
    output logic                                 mat1_valid,
    output logic                                 mat2_valid,
    output logic                                 busy,
    output logic                                 addr_overflow
);
    localparam int DATA_W = I_WIDTH + F_WIDTH;
    localparam int DIM_W  = $clog2(SPECTRAL_BANDS);
    // Wide enough for base + (max index * max stride) + max index without wrap.
    localparam int SUM_W  = ADDR_WIDTH + 2 * DIM_W + 2;

    logic [ADDR_WIDTH-1:0]   base1_reg, base2_reg;
    logic [DIM_W:0]          stride1_reg, stride2_reg;
    logic                    transpose_reg;

    logic                    mem_en_reg;
    logic [ADDR_WIDTH-1:0]   mem1_addr_reg, mem2_addr_reg;
    logic [READ_LATENCY-1:0] pipe_reg, pipe_next;
    logic [DATA_W-1:0]       mat1_reg, mat2_reg;
    logic                    valid_reg;
    logic                    overflow_reg;

    logic                    inflight, accept;
    logic [ADDR_WIDTH-1:0]   base1_eff, base2_eff;
    logic [DIM_W:0]          stride1_eff, stride2_eff;
    logic                    transpose_eff;
    logic [DIM_W-1:0]        mat2_major, mat2_minor;
    logic [SUM_W-1:0]        addr1_full, addr2_full;
    logic                    overflow_now;

    assign inflight = mem_en_reg | (|pipe_reg) | valid_reg;
    assign accept   = start & ~inflight;

    // A request arriving together with an accepted start uses the new configuration.
    always_comb begin
        base1_eff     = accept ? mat1_base      : base1_reg;
        base2_eff     = accept ? mat2_base      : base2_reg;
        stride1_eff   = accept ? mat1_stride    : stride1_reg;
        stride2_eff   = accept ? mat2_stride    : stride2_reg;
        transpose_eff = accept ? mat2_transpose : transpose_reg;
    end

    always_comb begin
        mat2_major   = transpose_eff ? mat2_col : mat2_row;
        mat2_minor   = transpose_eff ? mat2_row : mat2_col;
        addr1_full   = SUM_W'(base1_eff) + SUM_W'(mat1_row) * SUM_W'(stride1_eff)
                     + SUM_W'(mat1_col);
        addr2_full   = SUM_W'(base2_eff) + SUM_W'(mat2_major) * SUM_W'(stride2_eff)
                     + SUM_W'(mat2_minor);
        overflow_now = (|addr1_full[SUM_W-1:ADDR_WIDTH]) | (|addr2_full[SUM_W-1:ADDR_WIDTH]);
    end

    generate
        if (READ_LATENCY == 1) begin : g_pipe_one
            assign pipe_next = mem_en_reg;
        end else begin : g_pipe_many
            assign pipe_next = {pipe_reg[READ_LATENCY-2:0], mem_en_reg};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            base1_reg     <= '0;
            base2_reg     <= '0;
            stride1_reg   <= '0;
            stride2_reg   <= '0;
            transpose_reg <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem1_addr_reg <= '0;
            mem2_addr_reg <= '0;
            pipe_reg      <= '0;
            mat1_reg      <= '0;
            mat2_reg      <= '0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (accept) begin
                base1_reg     <= mat1_base;
                base2_reg     <= mat2_base;
                stride1_reg   <= mat1_stride;
                stride2_reg   <= mat2_stride;
                transpose_reg <= mat2_transpose;
            end
            mem_en_reg <= rd_addr_valid;
            if (rd_addr_valid) begin
                mem1_addr_reg <= addr1_full[ADDR_WIDTH-1:0];
                mem2_addr_reg <= addr2_full[ADDR_WIDTH-1:0];
            end
            // An overflow in the bypassed request wins over the clear from start.
            if (rd_addr_valid && overflow_now) begin
                overflow_reg <= 1'b1;
            end else if (accept) begin
                overflow_reg <= 1'b0;
            end
            pipe_reg  <= pipe_next;
            valid_reg <= pipe_reg[READ_LATENCY-1];
            if (pipe_reg[READ_LATENCY-1]) begin
                mat1_reg <= mem1_rdata;
                mat2_reg <= mem2_rdata;
            end
        end
    end

    assign mem1_en       = mem_en_reg;
    assign mem2_en       = mem_en_reg;
    assign mem1_addr     = mem1_addr_reg;
    assign mem2_addr     = mem2_addr_reg;
    assign mat1          = mat1_reg;
    assign mat2          = mat2_reg;
    assign mat1_valid    = valid_reg;
    assign mat2_valid    = valid_reg;
    assign addr_overflow = overflow_reg;
    assign busy          = rd_addr_valid | inflight;
endmodule

// File: tb/tb_mat_operand_fetch.sv
// Directed testbench for mat_operand_fetch with a two-cycle synchronous memory model.
module tb_mat_operand_fetch;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst, start, mat2_transpose, rd_addr_valid;
    logic [AW-1:0] mat1_base, mat2_base;
    logic [7:0]    mat1_stride, mat2_stride;
    logic [6:0]    mat1_row, mat1_col, mat2_row, mat2_col;
    logic          mem1_en, mem2_en, mat1_valid, mat2_valid, busy, addr_overflow;
    logic [AW-1:0] mem1_addr, mem2_addr;
    logic [DW-1:0] mem1_rdata, mem2_rdata, mat1, mat2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] mem1 [1 << AW];
    logic [DW-1:0] mem2 [1 << AW];
    logic [DW-1:0] m1_pipe [RL];
    logic [DW-1:0] m2_pipe [RL];

    always #5 clk = ~clk;

    mat_operand_fetch dut (
        .clk(clk), .rst(rst), .start(start),
        .mat1_base(mat1_base), .mat2_base(mat2_base),
        .mat1_stride(mat1_stride), .mat2_stride(mat2_stride),
        .mat2_transpose(mat2_transpose), .rd_addr_valid(rd_addr_valid),
        .mat1_row(mat1_row), .mat1_col(mat1_col), .mat2_row(mat2_row), .mat2_col(mat2_col),
        .mem1_en(mem1_en), .mem2_en(mem2_en), .mem1_addr(mem1_addr), .mem2_addr(mem2_addr),
        .mem1_rdata(mem1_rdata), .mem2_rdata(mem2_rdata),
        .mat1(mat1), .mat2(mat2), .mat1_valid(mat1_valid), .mat2_valid(mat2_valid),
        .busy(busy), .addr_overflow(addr_overflow)
    );

    // Memory model: data appears RL cycles after the enable is seen.
    always @(posedge clk) begin
        if (mem1_en) m1_pipe[0] <= mem1[mem1_addr];
        if (mem2_en) m2_pipe[0] <= mem2[mem2_addr];
        for (int i = 1; i < RL; i++) begin
            m1_pipe[i] <= m1_pipe[i-1];
            m2_pipe[i] <= m2_pipe[i-1];
        end
    end
    assign mem1_rdata = m1_pipe[RL-1];
    assign mem2_rdata = m2_pipe[RL-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [AW-1:0] b1, input logic [7:0] s1,
                             input logic [AW-1:0] b2, input logic [7:0] s2, input logic tr);
        mat1_base = b1; mat1_stride = s1; mat2_base = b2; mat2_stride = s2;
        mat2_transpose = tr; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic request(input logic [6:0] r1, input logic [6:0] c1,
                           input logic [6:0] r2, input logic [6:0] c2);
        rd_addr_valid = 1'b1;
        mat1_row = r1; mat1_col = c1; mat2_row = r2; mat2_col = c2;
    endtask

    task automatic drain();
        rd_addr_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; start = 1'b0; rd_addr_valid = 1'b0; mat2_transpose = 1'b0;
        mat1_base = '0; mat2_base = '0; mat1_stride = '0; mat2_stride = '0;
        mat1_row = '0; mat1_col = '0; mat2_row = '0; mat2_col = '0;
        tick(); tick();
        rst = 1'b0;
        tests_run++;
        if ({mem1_en, mem2_en, mem1_addr, mem2_addr} !== '0) begin
            tests_failed++; $display("FAIL reset_mem got en=%b%b a1=%h a2=%h expected 0", mem1_en, mem2_en, mem1_addr, mem2_addr);
        end
        tests_run++;
        if ({mat1, mat2, mat1_valid, mat2_valid} !== '0) begin
            tests_failed++; $display("FAIL reset_mat got mat1=%h mat2=%h v=%b%b expected 0", mat1, mat2, mat1_valid, mat2_valid);
        end
        tests_run++;
        if ({busy, addr_overflow} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_flags got busy=%b ovf=%b expected 0", busy, addr_overflow);
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (mat1_valid || mat2_valid || busy) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("FAIL reset_idle got %0d active cycles expected 0", seen);
        end
        $display("[TB] reset/idle done");
    endtask

    task automatic test_single();
        configure(14'h100, 8'd4, 14'h200, 8'd3, 1'b0);
        request(7'd2, 7'd1, 7'd1, 7'd2);
        tick();
        rd_addr_valid = 1'b0;
        tests_run++;
        if (mem1_addr !== 14'h109 || mem2_addr !== 14'h205) begin
            tests_failed++; $display("FAIL single_addr got %h/%h expected 0109/0205", mem1_addr, mem2_addr);
        end
        tests_run++;
        if ({mem1_en, mem2_en, busy} !== 3'b111) begin
            tests_failed++; $display("FAIL single_en got en=%b%b busy=%b expected 111", mem1_en, mem2_en, busy);
        end
        tick();
        tests_run++;
        if ({mem1_en, mat1_valid} !== 2'b00) begin
            tests_failed++; $display("FAIL single_en_pulse got en=%b v=%b expected 00", mem1_en, mat1_valid);
        end
        tick();
        tests_run++;
        if (mat1_valid !== 1'b0) begin
            tests_failed++; $display("FAIL single_early_valid got %b expected 0", mat1_valid);
        end
        tick();
        tests_run++;
        if ({mat1_valid, mat2_valid} !== 2'b11 || mat1 !== 32'hAAAA0000 || mat2 !== 32'h00015555) begin
            tests_failed++; $display("FAIL single_data got v=%b%b %h/%h expected 11 AAAA0000/00015555", mat1_valid, mat2_valid, mat1, mat2);
        end
        $display("[TB] single txn mat1=%h mat2=%h", mat1, mat2);
        tick();
        tests_run++;
        if (mat1_valid !== 1'b0 || mat1 !== 32'hAAAA0000 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL single_hold got v=%b mat1=%h busy=%b expected 0 AAAA0000 0", mat1_valid, mat1, busy);
        end
    endtask

    task automatic test_transpose();
        configure(14'h000, 8'd4, 14'h000, 8'd5, 1'b1);
        request(7'd1, 7'd2, 7'd3, 7'd2);
        tick();
        tests_run++;
        if (mem2_addr !== 14'd13 || mem1_addr !== 14'd6) begin
            tests_failed++; $display("FAIL transpose_addr got %0d/%0d expected 6/13", mem1_addr, mem2_addr);
        end
        $display("[TB] transpose txn a1=%0d a2=%0d", mem1_addr, mem2_addr);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp1 [$];
        logic [DW-1:0] exp2 [$];
        logic [DW-1:0] e1, e2;
        int n, first, last, cnt;
        configure(14'h040, 8'd3, 14'h080, 8'd2, 1'b0);
        n = 0; first = -1; last = -1; cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (n < 12) begin
                // Walk i (row of A), j (col of B), k (inner index).
                request(7'(n / 6), 7'(n % 3), 7'(n % 3), 7'((n / 3) % 2));
                exp1.push_back(mem1[14'h040 + (n / 6) * 3 + (n % 3)]);
                exp2.push_back(mem2[14'h080 + (n % 3) * 2 + (n / 3) % 2]);
                n++;
            end else begin
                rd_addr_valid = 1'b0;
            end
            tick();
            if (mat1_valid) begin
                if (first < 0) first = c;
                last = c; cnt++;
                e1 = (exp1.size() > 0) ? exp1.pop_front() : '0;
                e2 = (exp2.size() > 0) ? exp2.pop_front() : '0;
                $display("[TB] stream txn %0d mat1=%h mat2=%h", cnt - 1, mat1, mat2);
                tests_run++;
                if (mat1 !== e1 || mat2 !== e2 || mat2_valid !== 1'b1) begin
                    tests_failed++; $display("FAIL stream_data[%0d] got %h/%h v2=%b expected %h/%h 1", cnt - 1, mat1, mat2, mat2_valid, e1, e2);
                end
            end
        end
        tests_run++;
        if (cnt !== 12 || last - first !== 11 || first !== RL + 1) begin
            tests_failed++; $display("FAIL stream_shape got cnt=%0d first=%0d last=%0d expected 12 3 14", cnt, first, last);
        end
    endtask

    task automatic test_overflow();
        configure(14'h3FF0, 8'd16, 14'h000, 8'd1, 1'b0);
        request(7'd1, 7'd0, 7'd0, 7'd0);
        tick();
        tests_run++;
        if (mem1_addr !== 14'h0000 || addr_overflow !== 1'b1) begin
            tests_failed++; $display("FAIL overflow_set got a1=%h ovf=%b expected 0000 1", mem1_addr, addr_overflow);
        end
        drain();
        tests_run++;
        if (addr_overflow !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL overflow_sticky got ovf=%b busy=%b expected 1 0", addr_overflow, busy);
        end
        configure(14'h000, 8'd4, 14'h000, 8'd4, 1'b0);
        tests_run++;
        if (addr_overflow !== 1'b0) begin
            tests_failed++; $display("FAIL overflow_clear got %b expected 0", addr_overflow);
        end
        $display("[TB] overflow txn done");
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        configure(14'h000, 8'd4, 14'h000, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            request(7'(i), 7'd0, 7'd0, 7'(i));
            tick();
        end
        rd_addr_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({busy, mem1_en, mat1_valid, mat2_valid} !== 4'b0000 || mat1 !== '0) begin
            tests_failed++; $display("FAIL rst_burst_state got busy=%b en=%b v=%b%b mat1=%h expected 0", busy, mem1_en, mat1_valid, mat2_valid, mat1);
        end
        seen = 0;
        repeat (10) begin
            tick();
            if (mat1_valid || mat2_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++; $display("FAIL rst_burst_valid got %0d valids expected 0", seen);
        end
        $display("[TB] reset mid-burst done");
    endtask

    task automatic test_start_ignored();
        configure(14'h000, 8'd4, 14'h020, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            request(7'(i), 7'd1, 7'd1, 7'(i));
            if (i == 2) begin
                start = 1'b1; mat1_base = 14'h1000; mat2_base = 14'h1000; mat2_transpose = 1'b1;
            end
            tick();
            start = 1'b0;
            tests_run++;
            if (mem1_addr !== 14'(i * 4 + 1) || mem2_addr !== 14'(32'h24 + i)) begin
                tests_failed++; $display("FAIL ignore_start[%0d] got %h/%h expected %h/%h", i, mem1_addr, mem2_addr, 14'(i * 4 + 1), 14'(32'h24 + i));
            end
        end
        drain();
        request(7'd1, 7'd1, 7'd2, 7'd1);
        tick();
        tests_run++;
        if (mem1_addr !== 14'd5 || mem2_addr !== 14'h029) begin
            tests_failed++; $display("FAIL ignore_start_after got %h/%h expected 0005/0029", mem1_addr, mem2_addr);
        end
        drain();
        // Start together with a request while idle: the request sees the new setup.
        mat1_base = 14'h300; mat1_stride = 8'd2; mat2_base = 14'h010; mat2_stride = 8'd7;
        mat2_transpose = 1'b1; start = 1'b1;
        request(7'd1, 7'd1, 7'd1, 7'd2);
        tick();
        start = 1'b0; rd_addr_valid = 1'b0;
        tests_run++;
        if (mem1_addr !== 14'h303 || mem2_addr !== 14'h01F) begin
            tests_failed++; $display("FAIL bypass got %h/%h expected 0303/001F", mem1_addr, mem2_addr);
        end
        $display("[TB] start-ignore/bypass done");
        drain();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem1[i] = 32'h1100_0000 | 32'(i);
            mem2[i] = 32'h2200_0000 | 32'(i);
        end
        mem1[14'h109] = 32'hAAAA0000;
        mem2[14'h205] = 32'h00015555;
        for (int i = 0; i < RL; i++) begin
            m1_pipe[i] = '0;
            m2_pipe[i] = '0;
        end
        test_reset();
        test_single();
        test_transpose();
        test_back_to_back();
        test_overflow();
        test_reset_mid_burst();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
